lsu: RTL and testbench
======================

// Module: lsu
// PURPOSE
//  RV32I load/store unit, directly downstream of the ALU in the execute stage.
//  Uses the ALU result (in0 + in1, ADD op) as the effective address.
//  Issues one data-memory request per load/store over a valid/ready handshake.
//  Aligns, byte-enables and sign/zero-extends data; returns load results for writeback.
// PARAMETERS
//  N_BITS  32  data/address width; only 32 is supported (byte enables are 4 bits)
//  N_IDX   5   destination register index width
// PORTS
//  clk              in   1       clock; all state updates on rising edge
//  rst              in   1       reset, synchronous, active-high
//  ex_valid         in   1       execute stage presents a memory op
//  ex_ready         out  1       LSU can accept an op; = (state==IDLE) && !rst
//  is_store         in   1       1 = store, 0 = load
//  funct3           in   3       RV32I funct3: LB/LH/LW/LBU/LHU, SB/SH/SW
//  addr             in   N_BITS  effective address (ALU out)
//  wdata            in   N_BITS  store data (rs2)
//  rd_idx           in   N_IDX   load destination register
//  dmem_req_valid   out  1       memory request valid
//  dmem_req_ready   in   1       memory accepts request
//  dmem_req_we      out  1       1 = write
//  dmem_req_addr    out  N_BITS  word-aligned address {addr[31:2],2'b00}
//  dmem_req_be      out  4       byte enables
//  dmem_req_wdata   out  N_BITS  lane-replicated store data
//  dmem_resp_valid  in   1       read data valid
//  dmem_resp_rdata  in   N_BITS  read word
//  wb_valid         out  1       one-cycle pulse: load result ready
//  wb_rd_idx        out  N_IDX   load destination
//  wb_data          out  N_BITS  extended load data
//  fault            out  1       one-cycle pulse: misaligned or illegal funct3
//  fault_addr       out  N_BITS  offending address, held until next fault
// BEHAVIOUR
//  Reset: state IDLE; every registered output 0 (req_*, wb_*, fault, fault_addr).
//  Accept on ex_valid && ex_ready: latch is_store, funct3, addr, wdata, rd_idx.
//  Legal ops: loads 000,001,010,100,101; stores 000,001,010. Anything else is illegal.
//  Misaligned: halfword with addr[0]!=0; word with addr[1:0]!=0.
//  Illegal or misaligned: no memory request. Next cycle: fault=1, fault_addr=addr. Stay IDLE.
//  FSM states: IDLE -> REQ on accepting a legal op.
//  REQ: dmem_req_* registered and held stable until dmem_req_ready.
//   REQ on handshake: store -> IDLE; load -> WAIT.
//  WAIT: on dmem_resp_valid, register the wb outputs; wb_valid pulses the next cycle; -> IDLE.
//  dmem_resp_valid is ignored outside WAIT.
//  Store byte enables: SB be=4'b0001<<addr[1:0], data={4{wdata[7:0]}}.
//   SH be=4'b0011<<addr[1:0], data={2{wdata[15:0]}}. SW be=4'b1111, data=wdata.
//  Load extraction: lane chosen by latched addr[1:0].
//   LB/LH sign-extend; LBU/LHU zero-extend; LW passes the full word.
//  Loads: dmem_req_we=0, be=4'b1111.
//  Minimum load latency: accept at T, request at T+1 (ready=1), response at T+2,
//   wb_valid at T+3. Minimum store: accept at T, handshake at T+1, ex_ready=1 at T+2.
//  Exactly one op in flight; ex_ready=0 in REQ and WAIT.
//  rst mid-operation: abandon the op, drop dmem_req_valid next cycle, no wb_valid or fault.
//   A late dmem_resp_valid after reset is ignored.
// TESTING
//  LB addr=0x1003, rdata=0x80FF_FF7F -> be=1111, req_addr=0x1000, wb_data=0xFFFF_FF80.
//  LHU addr=0x2002, rdata=0xBEEF_1234 -> wb_data=0x0000_BEEF, wb_rd_idx matches rd_idx.
//  SH addr=0x10, wdata=0x1234_ABCD -> be=0011, wdata=0xABCD_ABCD, we=1, no wb_valid.
//   Same with addr=0x12 -> be=1100.
//  LW addr=0x0000_0006 -> fault=1 one cycle, fault_addr=0x6, no dmem_req_valid, ex_ready stays 1.
//  SW with dmem_req_ready low for 5 cycles -> req_* stable throughout, ex_ready=0.
//   ex_ready=1 one cycle after ready.
//  Load in WAIT, rst for 1 cycle, then resp_valid -> no wb_valid, state IDLE, outputs 0.

Source files
------------

// File: rtl/lsu.sv
// RV32I load/store unit: one data-memory request per op over valid/ready,
// with store lane replication/byte enables and load extraction/extension.
module lsu #(
  parameter int unsigned N_BITS = 32,
  parameter int unsigned N_IDX  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [N_BITS-1:0] addr,
  input  logic [N_BITS-1:0] wdata,
  input  logic [N_IDX-1:0]  rd_idx,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic              dmem_req_we,
  output logic [N_BITS-1:0] dmem_req_addr,
  output logic [3:0]        dmem_req_be,
  output logic [N_BITS-1:0] dmem_req_wdata,
  input  logic              dmem_resp_valid,
  input  logic [N_BITS-1:0] dmem_resp_rdata,
  output logic              wb_valid,
  output logic [N_IDX-1:0]  wb_rd_idx,
  output logic [N_BITS-1:0] wb_data,
  output logic              fault,
  output logic [N_BITS-1:0] fault_addr
);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e             state_q, state_d;
  logic               is_store_q;
  logic [2:0]         funct3_q;
  logic [1:0]         lane_q;
  logic [N_IDX-1:0]   rd_idx_q;

  logic               accept, legal, misaligned, go, bad;
  logic [3:0]         st_be;
  logic [N_BITS-1:0]  st_data;
  logic [7:0]         ld_byte;
  logic [15:0]        ld_half;
  logic [N_BITS-1:0]  ld_data;

  assign ex_ready = (state_q == StIdle) && !rst;
  assign accept   = ex_valid && ex_ready;

  always_comb begin
    legal      = 1'b0;
    misaligned = 1'b0;
    if (is_store) begin
      legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    end else begin
      legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
              (funct3 == 3'b100) || (funct3 == 3'b101);
    end
    if (funct3[1:0] == 2'b01) misaligned = addr[0];
    if (funct3[1:0] == 2'b10) misaligned = (addr[1:0] != 2'b00);
  end

  assign go  = accept && legal && !misaligned;
  assign bad = accept && !(legal && !misaligned);

  // Store lanes are replicated so the memory only needs the byte enables.
  always_comb begin
    st_be   = 4'b1111;
    st_data = wdata;
    unique case (funct3[1:0])
      2'b00: begin
        st_be   = 4'b0001 << addr[1:0];
        st_data = {4{wdata[7:0]}};
      end
      2'b01: begin
        st_be   = 4'b0011 << addr[1:0];
        st_data = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = dmem_resp_rdata[{lane_q, 3'b000} +: 8];
    ld_half = lane_q[1] ? dmem_resp_rdata[31:16] : dmem_resp_rdata[15:0];
    unique case (funct3_q)
      3'b000:  ld_data = {{(N_BITS-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{(N_BITS-16){ld_half[15]}}, ld_half};
      3'b100:  ld_data = {{(N_BITS-8){1'b0}}, ld_byte};
      3'b101:  ld_data = {{(N_BITS-16){1'b0}}, ld_half};
      default: ld_data = dmem_resp_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (go) state_d = StReq;
      StReq:   if (dmem_req_ready) state_d = is_store_q ? StIdle : StWait;
      StWait:  if (dmem_resp_valid) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      is_store_q     <= 1'b0;
      funct3_q       <= 3'b000;
      lane_q         <= 2'b00;
      rd_idx_q       <= '0;
      dmem_req_valid <= 1'b0;
      dmem_req_we    <= 1'b0;
      dmem_req_addr  <= '0;
      dmem_req_be    <= 4'b0000;
      dmem_req_wdata <= '0;
      wb_valid       <= 1'b0;
      wb_rd_idx      <= '0;
      wb_data        <= '0;
      fault          <= 1'b0;
      fault_addr     <= '0;
    end else begin
      fault    <= bad;
      wb_valid <= 1'b0;
      if (bad) fault_addr <= addr;
      if (go) begin
        is_store_q     <= is_store;
        funct3_q       <= funct3;
        lane_q         <= addr[1:0];
        rd_idx_q       <= rd_idx;
        dmem_req_valid <= 1'b1;
        dmem_req_we    <= is_store;
        dmem_req_addr  <= {addr[N_BITS-1:2], 2'b00};
        dmem_req_be    <= is_store ? st_be : 4'b1111;
        dmem_req_wdata <= st_data;
      end
      if (state_q == StReq && dmem_req_ready) dmem_req_valid <= 1'b0;
      if (state_q == StWait && dmem_resp_valid) begin
        wb_valid  <= 1'b1;
        wb_rd_idx <= rd_idx_q;
        wb_data   <= ld_data;
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: loads, stores, faults, backpressure and mid-op reset.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [4:0]  rd_idx;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic        dmem_req_we;
  logic [31:0] dmem_req_addr;
  logic [3:0]  dmem_req_be;
  logic [31:0] dmem_req_wdata;
  logic        dmem_resp_valid;
  logic [31:0] dmem_resp_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd_idx;
  logic [31:0] wb_data;
  logic        fault;
  logic [31:0] fault_addr;

  int checks = 0;
  int errors = 0;

  lsu #(.N_BITS(32), .N_IDX(5)) dut (
    .clk             (clk),
    .rst             (rst),
    .ex_valid        (ex_valid),
    .ex_ready        (ex_ready),
    .is_store        (is_store),
    .funct3          (funct3),
    .addr            (addr),
    .wdata           (wdata),
    .rd_idx          (rd_idx),
    .dmem_req_valid  (dmem_req_valid),
    .dmem_req_ready  (dmem_req_ready),
    .dmem_req_we     (dmem_req_we),
    .dmem_req_addr   (dmem_req_addr),
    .dmem_req_be     (dmem_req_be),
    .dmem_req_wdata  (dmem_req_wdata),
    .dmem_resp_valid (dmem_resp_valid),
    .dmem_resp_rdata (dmem_resp_rdata),
    .wb_valid        (wb_valid),
    .wb_rd_idx       (wb_rd_idx),
    .wb_data         (wb_data),
    .fault           (fault),
    .fault_addr      (fault_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] rd);
    is_store = st;
    funct3   = f3;
    addr     = a;
    wdata    = wd;
    rd_idx   = rd;
    ex_valid = 1'b1;
    step();
    ex_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (ex_ready !== 1'b0) begin
      errors++; $display("FAIL reset ex_ready_in_rst got %0b want 0", ex_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (ex_ready !== 1'b1) begin
      errors++; $display("FAIL reset ex_ready got %0b want 1", ex_ready);
    end
    checks++;
    if ({dmem_req_valid, dmem_req_we, dmem_req_be, wb_valid, fault} !== 8'h00) begin
      errors++; $display("FAIL reset ctrl got %0b/%0b/%b/%0b/%0b want 0", dmem_req_valid,
                         dmem_req_we, dmem_req_be, wb_valid, fault);
    end
    checks++;
    if ({dmem_req_addr, dmem_req_wdata, wb_data, fault_addr, wb_rd_idx} !== '0) begin
      errors++; $display("FAIL reset data got %h %h %h %h %h want 0", dmem_req_addr,
                         dmem_req_wdata, wb_data, fault_addr, wb_rd_idx);
    end
  endtask

  task automatic test_loads();
    logic [2:0]  f3_t  [5] = '{3'b000, 3'b101, 3'b010, 3'b001, 3'b100};
    logic [31:0] a_t   [5] = '{32'h1003, 32'h2002, 32'h100, 32'h3000, 32'h4001};
    logic [31:0] rd_t  [5] = '{32'h80FF_FF7F, 32'hBEEF_1234, 32'hDEAD_BEEF, 32'h0000_8001,
                               32'h0000_9A00};
    logic [31:0] exp_t [5] = '{32'hFFFF_FF80, 32'h0000_BEEF, 32'hDEAD_BEEF, 32'hFFFF_8001,
                               32'h0000_009A};
    logic [31:0] wa_t  [5] = '{32'h1000, 32'h2000, 32'h100, 32'h3000, 32'h4000};
    for (int i = 0; i < 5; i++) begin
      drive_op(1'b0, f3_t[i], a_t[i], 32'h5555_5555, 5'(i + 3));
      checks++;
      if (dmem_req_valid !== 1'b1 || dmem_req_we !== 1'b0 || dmem_req_be !== 4'b1111) begin
        errors++; $display("FAIL load%0d req got v=%0b we=%0b be=%b want 1 0 1111", i,
                           dmem_req_valid, dmem_req_we, dmem_req_be);
      end
      checks++;
      if (dmem_req_addr !== wa_t[i]) begin
        errors++; $display("FAIL load%0d req_addr got %h want %h", i, dmem_req_addr, wa_t[i]);
      end
      checks++;
      if (ex_ready !== 1'b0) begin
        errors++; $display("FAIL load%0d ex_ready_req got %0b want 0", i, ex_ready);
      end
      step();
      checks++;
      if (dmem_req_valid !== 1'b0 || ex_ready !== 1'b0 || wb_valid !== 1'b0) begin
        errors++; $display("FAIL load%0d wait got v=%0b rdy=%0b wb=%0b want 0 0 0", i,
                           dmem_req_valid, ex_ready, wb_valid);
      end
      dmem_resp_valid = 1'b1;
      dmem_resp_rdata = rd_t[i];
      step();
      dmem_resp_valid = 1'b0;
      dmem_resp_rdata = 32'h0;
      checks++;
      if (wb_valid !== 1'b1 || wb_data !== exp_t[i] || wb_rd_idx !== 5'(i + 3)) begin
        errors++; $display("FAIL load%0d wb got v=%0b d=%h rd=%0d want 1 %h %0d", i, wb_valid,
                           wb_data, wb_rd_idx, exp_t[i], i + 3);
      end
      step();
      checks++;
      if (wb_valid !== 1'b0 || ex_ready !== 1'b1) begin
        errors++; $display("FAIL load%0d after got wb=%0b rdy=%0b want 0 1", i, wb_valid,
                           ex_ready);
      end
    end
  endtask

  task automatic test_stores();
    logic [2:0]  f3_t [4] = '{3'b001, 3'b001, 3'b000, 3'b010};
    logic [31:0] a_t  [4] = '{32'h10, 32'h12, 32'h21, 32'h30};
    logic [31:0] wd_t [4] = '{32'h1234_ABCD, 32'h1234_ABCD, 32'h0000_005A, 32'hCAFE_F00D};
    logic [3:0]  be_t [4] = '{4'b0011, 4'b1100, 4'b0010, 4'b1111};
    logic [31:0] ed_t [4] = '{32'hABCD_ABCD, 32'hABCD_ABCD, 32'h5A5A_5A5A, 32'hCAFE_F00D};
    logic [31:0] wa_t [4] = '{32'h10, 32'h10, 32'h20, 32'h30};
    for (int i = 0; i < 4; i++) begin
      drive_op(1'b1, f3_t[i], a_t[i], wd_t[i], 5'd9);
      checks++;
      if (dmem_req_valid !== 1'b1 || dmem_req_we !== 1'b1 || dmem_req_be !== be_t[i]) begin
        errors++; $display("FAIL store%0d req got v=%0b we=%0b be=%b want 1 1 %b", i,
                           dmem_req_valid, dmem_req_we, dmem_req_be, be_t[i]);
      end
      checks++;
      if (dmem_req_wdata !== ed_t[i] || dmem_req_addr !== wa_t[i]) begin
        errors++; $display("FAIL store%0d data got %h@%h want %h@%h", i, dmem_req_wdata,
                           dmem_req_addr, ed_t[i], wa_t[i]);
      end
      step();
      checks++;
      if (dmem_req_valid !== 1'b0 || ex_ready !== 1'b1 || wb_valid !== 1'b0) begin
        errors++; $display("FAIL store%0d done got v=%0b rdy=%0b wb=%0b want 0 1 0", i,
                           dmem_req_valid, ex_ready, wb_valid);
      end
      step();
      checks++;
      if (wb_valid !== 1'b0) begin
        errors++; $display("FAIL store%0d no_wb got %0b want 0", i, wb_valid);
      end
    end
  endtask

  task automatic test_faults();
    logic        st_t [3] = '{1'b0, 1'b1, 1'b0};
    logic [2:0]  f3_t [3] = '{3'b010, 3'b100, 3'b001};
    logic [31:0] a_t  [3] = '{32'h6, 32'h40, 32'h1};
    for (int i = 0; i < 3; i++) begin
      drive_op(st_t[i], f3_t[i], a_t[i], 32'h0, 5'd1);
      checks++;
      if (fault !== 1'b1 || fault_addr !== a_t[i]) begin
        errors++; $display("FAIL fault%0d pulse got f=%0b a=%h want 1 %h", i, fault,
                           fault_addr, a_t[i]);
      end
      checks++;
      if (dmem_req_valid !== 1'b0 || ex_ready !== 1'b1) begin
        errors++; $display("FAIL fault%0d noreq got v=%0b rdy=%0b want 0 1", i,
                           dmem_req_valid, ex_ready);
      end
      step();
      checks++;
      if (fault !== 1'b0 || fault_addr !== a_t[i] || dmem_req_valid !== 1'b0) begin
        errors++; $display("FAIL fault%0d hold got f=%0b a=%h v=%0b want 0 %h 0", i, fault,
                           fault_addr, dmem_req_valid, a_t[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    dmem_req_ready = 1'b0;
    drive_op(1'b1, 3'b010, 32'h80, 32'h1122_3344, 5'd2);
    for (int i = 0; i < 5; i++) begin
      // A competing op offered during the stall must not be taken.
      is_store = 1'b1; funct3 = 3'b000; addr = 32'h99; wdata = 32'hFF; ex_valid = 1'b1;
      checks++;
      if (dmem_req_valid !== 1'b1 || ex_ready !== 1'b0 || dmem_req_be !== 4'b1111 ||
          dmem_req_addr !== 32'h80 || dmem_req_wdata !== 32'h1122_3344 || dmem_req_we !== 1'b1)
      begin
        errors++; $display("FAIL stall%0d got v=%0b rdy=%0b be=%b a=%h d=%h want 1 0 1111 80 11223344",
                           i, dmem_req_valid, ex_ready, dmem_req_be, dmem_req_addr,
                           dmem_req_wdata);
      end
      step();
    end
    ex_valid = 1'b0;
    dmem_req_ready = 1'b1;
    step();
    checks++;
    if (dmem_req_valid !== 1'b0 || ex_ready !== 1'b1) begin
      errors++; $display("FAIL stall_release got v=%0b rdy=%0b want 0 1", dmem_req_valid,
                         ex_ready);
    end
  endtask

  task automatic test_reset_mid();
    drive_op(1'b0, 3'b010, 32'h50, 32'h0, 5'd7);
    step();
    checks++;
    if (ex_ready !== 1'b0 || dmem_req_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid wait got rdy=%0b v=%0b want 0 0", ex_ready,
                         dmem_req_valid);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    dmem_resp_valid = 1'b1;
    dmem_resp_rdata = 32'h7777_7777;
    step();
    dmem_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wb_valid !== 1'b0 || fault !== 1'b0 || dmem_req_valid !== 1'b0 || ex_ready !== 1'b1 ||
          wb_data !== 32'h0 || dmem_req_addr !== 32'h0) begin
        errors++; $display("FAIL rstmid%0d got wb=%0b f=%0b v=%0b rdy=%0b d=%h a=%h want 0 0 0 1 0 0",
                           i, wb_valid, fault, dmem_req_valid, ex_ready, wb_data,
                           dmem_req_addr);
      end
      step();
    end
  endtask

  initial begin
    rst = 1'b1; ex_valid = 1'b0; is_store = 1'b0; funct3 = 3'b000;
    addr = 32'h0; wdata = 32'h0; rd_idx = 5'd0;
    dmem_req_ready = 1'b1; dmem_resp_valid = 1'b0; dmem_resp_rdata = 32'h0;
    #1;
    test_reset();
    test_loads();
    test_stores();
    test_faults();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
